aq_lsu_req_queue: RTL and testbench

- NUM-entry LSU request buffer that sits directly upstream of the aq_prio LRU arbiter.
- Holds outstanding load/store bus requests and presents their pending-valid vector to the arbiter.
- Consumes the arbiter's one-hot select and drives the selected request onto the issue port.
- Pulses the arbiter clear on an issue handshake, then tracks each issued entry until its response returns.

---
 rtl/aq_lsu_req_queue.sv | 137 +++++++++++++
 tb/tb_aq_lsu_req_queue.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aq_lsu_req_queue.sv
// aq_lsu_req_queue: NUM-entry LSU request buffer feeding the aq_prio LRU arbiter.
// Entries move FREE -> PEND (alloc) -> ISSUED (issue handshake) -> FREE (response).
module aq_lsu_req_queue #(
  parameter int unsigned NUM = 4,
  parameter int unsigned IDW = 2,
  parameter int unsigned AW  = 40,
  parameter int unsigned DW  = 64
) (
  input  logic           clk,
  input  logic           rst_b,
  input  logic           alloc_vld,
  input  logic [AW-1:0]  alloc_addr,
  input  logic [DW-1:0]  alloc_data,
  output logic           alloc_rdy,
  input  logic           flush,
  output logic [NUM-1:0] arb_valid,
  input  logic [NUM-1:0] arb_sel,
  output logic           arb_clr,
  output logic           issue_vld,
  output logic [AW-1:0]  issue_addr,
  output logic [DW-1:0]  issue_data,
  output logic [IDW-1:0] issue_id,
  input  logic           issue_rdy,
  input  logic           resp_vld,
  input  logic [IDW-1:0] resp_id,
  output logic           empty
);

  typedef enum logic [1:0] {
    ST_FREE   = 2'b00,
    ST_PEND   = 2'b01,
    ST_ISSUED = 2'b10
  } ent_st_e;

  ent_st_e        r_st     [NUM];
  ent_st_e        w_st_nxt [NUM];
  logic [AW-1:0]  r_addr   [NUM];
  logic [DW-1:0]  r_data   [NUM];

  logic [NUM-1:0] w_pend;
  logic [NUM-1:0] w_free;
  logic [NUM-1:0] w_alloc_oh;
  logic [NUM-1:0] w_sel_m;
  logic           w_found;
  logic           w_alloc_fire;
  logic           w_issue_fire;

  // Per-entry status decode from registered state
  always_comb begin
    w_pend = '0;
    w_free = '0;
    for (int unsigned i = 0; i < NUM; i++) begin
      w_pend[i] = (r_st[i] == ST_PEND);
      w_free[i] = (r_st[i] == ST_FREE);
    end
  end

  // Lowest-index FREE entry is the allocation target
  always_comb begin
    w_alloc_oh = '0;
    w_found    = 1'b0;
    for (int unsigned i = 0; i < NUM; i++) begin
      if (w_free[i] && !w_found) begin
        w_alloc_oh[i] = 1'b1;
        w_found       = 1'b1;
      end
    end
  end

  assign alloc_rdy    = (|w_free) & ~flush;
  assign w_alloc_fire = alloc_vld & alloc_rdy;
  assign arb_valid    = w_pend;
  assign w_sel_m      = arb_sel & w_pend;
  assign issue_vld    = (|w_sel_m) & ~flush;
  assign w_issue_fire = issue_vld & issue_rdy;
  assign arb_clr      = w_issue_fire;
  assign empty        = &w_free;

  // AND-OR issue mux over the masked grant
  always_comb begin
    issue_addr = '0;
    issue_data = '0;
    issue_id   = '0;
    for (int unsigned i = 0; i < NUM; i++) begin
      issue_addr = issue_addr | ({AW{w_sel_m[i]}} & r_addr[i]);
      issue_data = issue_data | ({DW{w_sel_m[i]}} & r_data[i]);
      issue_id   = issue_id   | ({IDW{w_sel_m[i]}} & IDW'(i));
    end
  end

  // Next-state: alloc, issue, flush and response act on disjoint start-of-cycle states
  always_comb begin
    for (int unsigned i = 0; i < NUM; i++) begin
      w_st_nxt[i] = r_st[i];
      if (w_alloc_fire && w_alloc_oh[i]) begin
        w_st_nxt[i] = ST_PEND;
      end
      if (w_issue_fire && w_sel_m[i]) begin
        w_st_nxt[i] = ST_ISSUED;
      end
      if (flush && (r_st[i] == ST_PEND)) begin
        w_st_nxt[i] = ST_FREE;
      end
      if (resp_vld && (resp_id == IDW'(i)) && (r_st[i] == ST_ISSUED)) begin
        w_st_nxt[i] = ST_FREE;
      end
    end
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM; i++) begin
      if (!rst_b) begin
        r_st[i] <= ST_FREE;
      end else begin
        r_st[i] <= w_st_nxt[i];
      end
    end
  end

  // Payload capture on allocation; PEND/ISSUED entries are never rewritten
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM; i++) begin
      if (w_alloc_fire && w_alloc_oh[i]) begin
        r_addr[i] <= alloc_addr;
        r_data[i] <= alloc_data;
      end
    end
  end

`ifndef SYNTHESIS
  // Multi-hot grants are unsupported
  a_sel_onehot0: assert property (@(posedge clk) disable iff (!rst_b) $onehot0(arb_sel))
    else $error("aq_lsu_req_queue: arb_sel is multi-hot: %b", arb_sel);
`endif

endmodule

// File: tb/tb_aq_lsu_req_queue.sv
// Bench for aq_lsu_req_queue: directed scenarios plus randomized traffic against an entry-table model.
module tb_aq_lsu_req_queue;

  localparam int unsigned NUM = 4;
  localparam int unsigned IDW = 2;
  localparam int unsigned AW  = 40;
  localparam int unsigned DW  = 64;
  localparam int FREE = 0, PEND = 1, ISS = 2;

  logic           clk = 1'b0;
  logic           rst_b;
  logic           alloc_vld;
  logic [AW-1:0]  alloc_addr;
  logic [DW-1:0]  alloc_data;
  logic           alloc_rdy;
  logic           flush;
  logic [NUM-1:0] arb_valid;
  logic [NUM-1:0] arb_sel;
  logic           arb_clr;
  logic           issue_vld;
  logic [AW-1:0]  issue_addr;
  logic [DW-1:0]  issue_data;
  logic [IDW-1:0] issue_id;
  logic           issue_rdy;
  logic           resp_vld;
  logic [IDW-1:0] resp_id;
  logic           empty;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference: status and payload of each slot
  int            m_st   [NUM];
  logic [AW-1:0] m_addr [NUM];
  logic [DW-1:0] m_data [NUM];

  always #5 clk = ~clk;

  aq_lsu_req_queue #(.NUM(NUM), .IDW(IDW), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_b(rst_b),
    .alloc_vld(alloc_vld), .alloc_addr(alloc_addr), .alloc_data(alloc_data), .alloc_rdy(alloc_rdy),
    .flush(flush), .arb_valid(arb_valid), .arb_sel(arb_sel), .arb_clr(arb_clr),
    .issue_vld(issue_vld), .issue_addr(issue_addr), .issue_data(issue_data), .issue_id(issue_id),
    .issue_rdy(issue_rdy), .resp_vld(resp_vld), .resp_id(resp_id), .empty(empty)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic set_in(input logic rb, input logic av, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic fl, input logic [NUM-1:0] sel, input logic ir,
                        input logic rv, input logic [IDW-1:0] rid);
    rst_b = rb; alloc_vld = av; alloc_addr = a; alloc_data = d; flush = fl;
    arb_sel = sel; issue_rdy = ir; resp_vld = rv; resp_id = rid;
    #2;
  endtask

  function automatic int n_free();
    int n = 0;
    for (int i = 0; i < NUM; i++) if (m_st[i] == FREE) n++;
    return n;
  endfunction

  // Compare every output against what the slot table implies for the current inputs
  task automatic model_check();
    logic [NUM-1:0] ev;
    logic           eiv;
    int             sid;
    ev = '0;
    sid = -1;
    for (int i = 0; i < NUM; i++) begin
      ev[i] = (m_st[i] == PEND);
      if (arb_sel[i] && m_st[i] == PEND) sid = i;
    end
    eiv = (sid >= 0) && !flush;
    chk("empty", 64'(empty), 64'(n_free() == NUM));
    chk("alloc_rdy", 64'(alloc_rdy), 64'((n_free() > 0) && !flush));
    chk("arb_valid", 64'(arb_valid), 64'(ev));
    chk("issue_vld", 64'(issue_vld), 64'(eiv));
    chk("arb_clr", 64'(arb_clr), 64'(eiv && issue_rdy));
    if (eiv) begin
      chk("issue_id", 64'(issue_id), 64'(sid));
      chk("issue_addr", 64'(issue_addr), 64'(m_addr[sid]));
      chk("issue_data", 64'(issue_data), 64'(m_data[sid]));
    end
  endtask

  // Apply this cycle's inputs to the slot table, then move to the next cycle
  task automatic advance();
    int nx [NUM];
    int sid;
    sid = -1;
    for (int i = 0; i < NUM; i++) begin
      nx[i] = m_st[i];
      if (arb_sel[i] && m_st[i] == PEND) sid = i;
    end
    if (!rst_b) begin
      for (int i = 0; i < NUM; i++) nx[i] = FREE;
    end else begin
      if (alloc_vld && !flush) begin
        for (int i = 0; i < NUM; i++) begin
          if (m_st[i] == FREE) begin
            nx[i] = PEND; m_addr[i] = alloc_addr; m_data[i] = alloc_data;
            break;
          end
        end
      end
      if (flush) begin
        for (int i = 0; i < NUM; i++) if (m_st[i] == PEND) nx[i] = FREE;
      end else if (sid >= 0 && issue_rdy) begin
        nx[sid] = ISS;
      end
      if (resp_vld && m_st[int'(resp_id)] == ISS) nx[int'(resp_id)] = FREE;
    end
    for (int i = 0; i < NUM; i++) m_st[i] = nx[i];
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic rb, input logic av, input logic [AW-1:0] a,
                      input logic fl, input logic [NUM-1:0] sel, input logic ir,
                      input logic rv, input logic [IDW-1:0] rid);
    logic [63:0] d;
    d = {$urandom(), $urandom()};
    set_in(rb, av, a, d, fl, sel, ir, rv, rid);
    model_check();
    advance();
  endtask

  initial begin
    logic [63:0] rnd;
    int          pl [$];
    int          il [$];
    logic [NUM-1:0] sel;
    for (int i = 0; i < NUM; i++) m_st[i] = FREE;

    // Reset held two cycles
    set_in(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, '0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_alloc_rdy", 64'(alloc_rdy), 64'd1);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_arb_valid", 64'(arb_valid), 64'd0);
    chk("rst_issue_vld", 64'(issue_vld), 64'd0);
    chk("rst_arb_clr", 64'(arb_clr), 64'd0);

    // Fill all four entries
    for (int k = 0; k < 4; k++) step(1'b1, 1'b1, AW'(40'h100 + k), 1'b0, '0, 1'b0, 1'b0, '0);

    // Issue handshake on entry 2
    set_in(1'b1, 1'b0, '0, '0, 1'b0, 4'b0100, 1'b1, 1'b0, '0);
    chk("fill_arb_valid", 64'(arb_valid), 64'hf);
    chk("fill_alloc_rdy", 64'(alloc_rdy), 64'd0);
    chk("fill_empty", 64'(empty), 64'd0);
    chk("hs_issue_addr", 64'(issue_addr), 64'h102);
    chk("hs_issue_id", 64'(issue_id), 64'd2);
    chk("hs_arb_clr", 64'(arb_clr), 64'd1);
    model_check();
    advance();

    // Back-pressure on entry 0
    for (int k = 0; k < 3; k++) begin
      set_in(1'b1, 1'b0, '0, '0, 1'b0, 4'b0001, 1'b0, 1'b0, '0);
      chk("bp_arb_valid", 64'(arb_valid), 64'b1011);
      chk("bp_issue_vld", 64'(issue_vld), 64'd1);
      chk("bp_issue_addr", 64'(issue_addr), 64'h100);
      chk("bp_arb_clr", 64'(arb_clr), 64'd0);
      model_check();
      advance();
    end

    // Response frees entry 2 while alloc is refused in the same cycle
    set_in(1'b1, 1'b1, AW'(40'h200), 64'h55, 1'b0, '0, 1'b0, 1'b1, 2'd2);
    chk("col_alloc_rdy", 64'(alloc_rdy), 64'd0);
    model_check();
    advance();
    set_in(1'b1, 1'b1, AW'(40'h201), 64'h66, 1'b0, '0, 1'b0, 1'b0, '0);
    chk("col_alloc_rdy_next", 64'(alloc_rdy), 64'd1);
    model_check();
    advance();
    set_in(1'b1, 1'b0, '0, '0, 1'b0, 4'b0100, 1'b0, 1'b0, '0);
    chk("refill_addr", 64'(issue_addr), 64'h201);
    model_check();
    advance();

    // Issue entry 3, stray response to PEND entry 1, then flush
    step(1'b1, 1'b0, '0, 1'b0, 4'b1000, 1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 2'd1);
    set_in(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, '0);
    chk("stray_arb_valid", 64'(arb_valid), 64'b0111);
    model_check();
    advance();
    set_in(1'b1, 1'b1, AW'(40'h300), '0, 1'b1, 4'b0010, 1'b1, 1'b0, '0);
    chk("fl_issue_vld", 64'(issue_vld), 64'd0);
    chk("fl_arb_clr", 64'(arb_clr), 64'd0);
    chk("fl_alloc_rdy", 64'(alloc_rdy), 64'd0);
    model_check();
    advance();
    set_in(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, '0);
    chk("fl_arb_valid", 64'(arb_valid), 64'd0);
    chk("fl_empty", 64'(empty), 64'd0);
    model_check();
    advance();

    // Two PEND plus one ISSUED, then reset mid-operation
    step(1'b1, 1'b1, AW'(40'h400), 1'b0, '0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b1, AW'(40'h401), 1'b0, '0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0);
    set_in(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b1, 2'd3);
    chk("mrst_empty", 64'(empty), 64'd1);
    chk("mrst_arb_valid", 64'(arb_valid), 64'd0);
    model_check();
    advance();
    set_in(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, '0);
    chk("mrst_stale_resp", 64'(empty), 64'd1);
    model_check();
    advance();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      pl.delete(); il.delete();
      for (int i = 0; i < NUM; i++) begin
        if (m_st[i] == PEND) pl.push_back(i);
        if (m_st[i] == ISS) il.push_back(i);
      end
      sel = '0;
      if ($urandom_range(9) < 7 && pl.size() > 0) sel[pl[$urandom_range(pl.size() - 1)]] = 1'b1;
      else if ($urandom_range(3) == 0) sel[$urandom_range(NUM - 1)] = 1'b1;
      rnd = {$urandom(), $urandom()};
      step(($urandom_range(99) != 0),
           ($urandom_range(9) < 6),
           rnd[AW-1:0],
           ($urandom_range(19) == 0),
           sel,
           ($urandom_range(9) < 6),
           ($urandom_range(9) < 5),
           (il.size() > 0 && $urandom_range(3) != 0) ? IDW'(il[$urandom_range(il.size() - 1)])
                                                       : IDW'($urandom_range(NUM - 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
